// File: rtl/spawn_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : spawn_scheduler
// Brief    : Pausable, speed-ramping fruit spawn scheduler with LFSR lane pick
//            and a valid/ready spawn request toward the renderer.
// Revision : 1.0 - initial release
// ============================================================================
module spawn_scheduler #(
    parameter logic [19:0] INIT_PERIOD = 20'd770_000,
    parameter logic [19:0] MIN_PERIOD  = 20'd250_000,
    parameter logic [19:0] PERIOD_STEP = 20'd10,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic        C50,
    input  logic        Reset,
    input  logic        start,
    input  logic        pause,
    input  logic        game_over,
    input  logic        spawn_ready,
    output logic        spawn_valid,
    output logic [1:0]  spawn_lane,
    output logic        tick,
    output logic [19:0] period,
    output logic [15:0] spawn_count,
    output logic [7:0]  drop_count,
    output logic [1:0]  state
);

    localparam logic [1:0]  S_IDLE   = 2'd0;
    localparam logic [1:0]  S_RUN    = 2'd1;
    localparam logic [1:0]  S_PAUSED = 2'd2;
    localparam logic [1:0]  S_OVER   = 2'd3;
    localparam logic [15:0] C_LFSR_TAPS  = 16'hB400;
    localparam logic [20:0] C_RAMP_FLOOR = {1'b0, MIN_PERIOD} + {1'b0, PERIOD_STEP};

    logic [1:0]  state_q, state_d;
    logic [19:0] count_q, count_d;
    logic [19:0] period_q, period_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic        tick_q, tick_d;
    logic        valid_q, valid_d;
    logic [1:0]  lane_q, lane_d;
    logic [15:0] scount_q, scount_d;
    logic [7:0]  dcount_q, dcount_d;

    logic        w_in_game;
    logic        w_load;
    logic        w_leave;
    logic        w_advance;
    logic        w_expire;
    logic        w_accept;
    logic [15:0] w_lfsr_next;

    // ---------------- state register ----------------
    always_ff @(posedge C50) begin
        if (Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_OVER: if (start) state_d = S_RUN;
            S_RUN: begin
                if (game_over)  state_d = S_OVER;
                else if (pause) state_d = S_PAUSED;
            end
            S_PAUSED: begin
                if (game_over)   state_d = S_OVER;
                else if (!pause) state_d = S_RUN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- schedule / output logic ----------------
    assign w_in_game   = (state_q == S_RUN) || (state_q == S_PAUSED);
    assign w_load      = !w_in_game && start;
    assign w_leave     = w_in_game && game_over;
    // game_over outranks a coincident tick or accept: the game ends first.
    assign w_advance   = (state_q == S_RUN) && !game_over;
    assign w_expire    = w_advance && (count_q == period_q - 20'd1);
    assign w_accept    = w_in_game && !game_over && valid_q && spawn_ready;
    assign w_lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? C_LFSR_TAPS : 16'h0000);

    always_comb begin
        count_d  = count_q;
        period_d = period_q;
        lfsr_d   = lfsr_q;
        tick_d   = 1'b0;
        valid_d  = valid_q;
        lane_d   = lane_q;
        scount_d = scount_q;
        dcount_d = dcount_q;
        if (w_load) begin
            count_d  = 20'd0;
            period_d = INIT_PERIOD;
            lfsr_d   = LFSR_SEED;
            valid_d  = 1'b0;
            scount_d = 16'd0;
            dcount_d = 8'd0;
        end else if (w_leave) begin
            valid_d = 1'b0;
        end else begin
            if (w_accept) begin
                valid_d  = 1'b0;
                scount_d = scount_q + 16'd1;
            end
            if (w_expire) begin
                count_d  = 20'd0;
                tick_d   = 1'b1;
                period_d = ({1'b0, period_q} >= C_RAMP_FLOOR) ? (period_q - PERIOD_STEP)
                                                              : MIN_PERIOD;
                lfsr_d   = w_lfsr_next;
                if (!valid_q || w_accept) begin
                    valid_d = 1'b1;
                    lane_d  = w_lfsr_next[1:0];
                end else if (dcount_q != 8'hFF) begin
                    dcount_d = dcount_q + 8'd1;
                end
            end else if (w_advance) begin
                count_d = count_q + 20'd1;
            end
        end
    end

    always_ff @(posedge C50) begin
        if (Reset) begin
            count_q  <= 20'd0;
            period_q <= INIT_PERIOD;
            lfsr_q   <= LFSR_SEED;
            tick_q   <= 1'b0;
            valid_q  <= 1'b0;
            lane_q   <= 2'd0;
            scount_q <= 16'd0;
            dcount_q <= 8'd0;
        end else begin
            count_q  <= count_d;
            period_q <= period_d;
            lfsr_q   <= lfsr_d;
            tick_q   <= tick_d;
            valid_q  <= valid_d;
            lane_q   <= lane_d;
            scount_q <= scount_d;
            dcount_q <= dcount_d;
        end
    end

    assign spawn_valid = valid_q;
    assign spawn_lane  = lane_q;
    assign tick        = tick_q;
    assign period      = period_q;
    assign spawn_count = scount_q;
    assign drop_count  = dcount_q;
    assign state       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_spawn_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_spawn_scheduler
// Brief    : Self-checking bench for spawn_scheduler: directed scenarios plus
//            randomized traffic against a cycle-level behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spawn_scheduler;

    localparam int C_INIT = 10;
    localparam int C_MIN  = 6;
    localparam int C_STEP = 2;
    localparam int C_SEED = 16'hACE1;

    logic        C50 = 1'b0;
    logic        Reset = 1'b1;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic        game_over = 1'b0;
    logic        spawn_ready = 1'b0;
    logic        spawn_valid;
    logic [1:0]  spawn_lane;
    logic        tick;
    logic [19:0] period;
    logic [15:0] spawn_count;
    logic [7:0]  drop_count;
    logic [1:0]  state;

    int n_checks = 0;
    int n_fail   = 0;

    // behavioural model
    int m_state = 0, m_count = 0, m_period = C_INIT, m_lfsr = C_SEED;
    int m_tick = 0, m_valid = 0, m_lane = 0, m_scount = 0, m_dcount = 0;

    spawn_scheduler #(
        .INIT_PERIOD(20'd10),
        .MIN_PERIOD (20'd6),
        .PERIOD_STEP(20'd2),
        .LFSR_SEED  (16'hACE1)
    ) dut (
        .C50        (C50),
        .Reset      (Reset),
        .start      (start),
        .pause      (pause),
        .game_over  (game_over),
        .spawn_ready(spawn_ready),
        .spawn_valid(spawn_valid),
        .spawn_lane (spawn_lane),
        .tick       (tick),
        .period     (period),
        .spawn_count(spawn_count),
        .drop_count (drop_count),
        .state      (state)
    );

    always #5 C50 = ~C50;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int galois(input int x);
        return (x >> 1) ^ (((x & 1) != 0) ? 'hB400 : 0);
    endfunction

    task automatic model_step();
        int os;
        int old_valid;
        int acc;
        m_tick = 0;
        if (Reset) begin
            m_state = 0; m_count = 0; m_period = C_INIT; m_lfsr = C_SEED;
            m_valid = 0; m_lane = 0; m_scount = 0; m_dcount = 0;
            return;
        end
        os = m_state;
        if (os == 0 || os == 3) begin
            if (start) begin
                m_state = 1; m_count = 0; m_period = C_INIT; m_lfsr = C_SEED;
                m_valid = 0; m_scount = 0; m_dcount = 0;
            end
        end else if (game_over) begin
            m_state = 3;
            m_valid = 0;
        end else begin
            old_valid = m_valid;
            acc = (m_valid != 0 && spawn_ready) ? 1 : 0;
            if (acc != 0) begin
                m_valid = 0;
                m_scount = (m_scount + 1) % 65536;
            end
            if (os == 1) begin
                if (m_count + 1 == m_period) begin
                    m_count = 0;
                    m_tick = 1;
                    m_period = (m_period >= C_MIN + C_STEP) ? m_period - C_STEP : C_MIN;
                    m_lfsr = galois(m_lfsr);
                    if (old_valid == 0 || acc != 0) begin
                        m_valid = 1;
                        m_lane = m_lfsr % 4;
                    end else if (m_dcount < 255) begin
                        m_dcount++;
                    end
                end else begin
                    m_count++;
                end
            end
            m_state = pause ? 2 : 1;
        end
    endtask

    // one clock: model follows the sampled inputs, outputs compared 1 time unit later
    task automatic step();
        @(posedge C50);
        model_step();
        #1;
        check("state", state, m_state);
        check("tick", tick, m_tick);
        check("period", period, m_period);
        check("valid", spawn_valid, m_valid);
        check("lane", spawn_lane, m_lane);
        check("spawn_count", spawn_count, m_scount);
        check("drop_count", drop_count, m_dcount);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        int exp_t[5];
        int exp_p[5];
        int exp_l[5];
        int tq[$];
        int pq[$];
        int lq[$];
        exp_t = '{10, 18, 24, 30, 36};
        exp_p = '{8, 6, 6, 6, 6};
        exp_l = '{0, 0, 0, 2, 3};

        step();
        step();
        check("rst_state", state, 0);
        check("rst_period", period, C_INIT);
        check("rst_valid", spawn_valid, 0);
        check("rst_counts", {spawn_count, drop_count}, 0);
        Reset = 1'b0;
        step();

        // ramp, lane sequence, then game_over and restart
        for (int rep = 0; rep < 2; rep++) begin
            tq.delete(); pq.delete(); lq.delete();
            spawn_ready = 1'b1;
            pulse_start();
            for (int k = 1; k <= 40; k++) begin
                step();
                if (tick) begin
                    tq.push_back(k);
                    pq.push_back(int'(period));
                    lq.push_back(int'(spawn_lane));
                end
            end
            check("ramp_nticks", tq.size(), 5);
            for (int i = 0; i < 5 && i < tq.size(); i++) begin
                check("ramp_tick_cycle", tq[i], exp_t[i]);
                check("ramp_period", pq[i], exp_p[i]);
                check("ramp_lane", lq[i], exp_l[i]);
            end
            check("ramp_spawn_count", spawn_count, 5);
            game_over = 1'b1;
            step();
            game_over = 1'b0;
            check("over_state", state, 3);
        end

        // backpressure: three ticks with no acceptance
        spawn_ready = 1'b0;
        pulse_start();
        for (int k = 1; k <= 24; k++) step();
        check("bp_valid", spawn_valid, 1);
        check("bp_lane", spawn_lane, 0);
        check("bp_drops", drop_count, 2);
        check("bp_count_pre", spawn_count, 0);
        spawn_ready = 1'b1;
        step();
        check("bp_count_post", spawn_count, 1);
        check("bp_valid_post", spawn_valid, 0);
        game_over = 1'b1;
        step();
        game_over = 1'b0;

        // accept coinciding with a tick, then game_over with a pending spawn
        spawn_ready = 1'b1;
        pulse_start();
        for (int k = 1; k <= 30; k++) begin
            spawn_ready = (k <= 24 || k == 30);
            step();
        end
        check("sim_tick", tick, 1);
        check("sim_valid", spawn_valid, 1);
        check("sim_lane", spawn_lane, 2);
        check("sim_drops", drop_count, 0);
        check("sim_count", spawn_count, 3);
        spawn_ready = 1'b0;
        step();
        game_over = 1'b1;
        step();
        game_over = 1'b0;
        check("go_state", state, 3);
        check("go_valid", spawn_valid, 0);
        check("go_count", spawn_count, 3);
        pause = 1'b1;
        spawn_ready = 1'b1;
        for (int k = 0; k < 5; k++) step();
        check("go_hold_state", state, 3);
        check("go_hold_count", spawn_count, 3);
        pause = 1'b0;

        // pause of 7 cycles starting 3 cycles after a tick
        tq.delete();
        pulse_start();
        for (int k = 1; k <= 30; k++) begin
            pause = (k >= 13 && k <= 19);
            step();
            if (tick) tq.push_back(k);
            if (k == 15) begin
                check("pause_state", state, 2);
                check("pause_period", period, 8);
            end
        end
        pause = 1'b0;
        check("pause_nticks", tq.size() >= 2, 1);
        if (tq.size() >= 2) check("pause_gap", tq[1] - tq[0], 15);

        // game_over and start together in RUN
        game_over = 1'b1;
        start = 1'b1;
        step();
        game_over = 1'b0;
        start = 1'b0;
        check("go_start_state", state, 3);

        // Reset together with start
        Reset = 1'b1;
        start = 1'b1;
        step();
        Reset = 1'b0;
        start = 1'b0;
        check("rs_state", state, 0);
        check("rs_counts", {spawn_count, drop_count}, 0);
        check("rs_period", period, C_INIT);

        // randomized traffic
        for (int k = 0; k < 4000; k++) begin
            Reset       = ($urandom_range(0, 599) == 0);
            start       = ($urandom_range(0, 39) == 0);
            game_over   = ($urandom_range(0, 119) == 0);
            if ($urandom_range(0, 15) == 0) pause = ~pause;
            spawn_ready = ($urandom_range(0, 2) != 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
